// File: rtl/window_gen_mc.sv
// Multi-channel sliding-window generator: buffers NUM_CH parallel sample streams in a
// ring and emits a full WINDOW_SIZE-tap snapshot every STRIDE accepts once primed.
module window_gen_mc #(
  parameter int DATA_W      = 16,
  parameter int WINDOW_SIZE = 32,
  parameter int NUM_CH      = 8,
  parameter int STRIDE      = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [NUM_CH*DATA_W-1:0]                   in_sample,
  input  logic                                       in_last,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic signed [NUM_CH*WINDOW_SIZE*DATA_W-1:0] window,
  output logic                                       out_last,
  output logic [15:0]                                win_count
);

  localparam int SAMP_W = NUM_CH * DATA_W;
  localparam int WIN_W  = SAMP_W * WINDOW_SIZE;
  localparam int PTR_W  = $clog2(WINDOW_SIZE);
  localparam int FC_W   = $clog2(WINDOW_SIZE + 1);
  localparam int SC_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  // Handshake: a sample moves when in_valid && in_ready; a window moves when
  // out_valid && out_ready. Input stalls only while an untaken window is pending.
  logic [1:0]        rst_sync;
  logic              rst_int_n;
  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FC_W-1:0]   fill_cnt;
  logic [SC_W-1:0]   stride_cnt;
  logic [SAMP_W-1:0] ring [WINDOW_SIZE];
  logic [WIN_W-1:0]  cap_win;
  logic              accept;
  logic              capture;
  logic              wc_clear;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign capture  = accept &&
                    (((state == FILL) && (fill_cnt == FC_W'(WINDOW_SIZE - 1))) ||
                     ((state == RUN)  && (stride_cnt == SC_W'(STRIDE - 1))));
  assign wc_clear = (out_valid && out_ready && out_last) ||
                    (accept && in_last && !capture);

  // Oldest tap sits just past wr_ptr; the newest tap is the sample arriving now.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar k = 0; k < WINDOW_SIZE; k++) begin : g_tap
      if (k == WINDOW_SIZE - 1) begin : g_new
        assign cap_win[(c*WINDOW_SIZE+k)*DATA_W +: DATA_W] = in_sample[c*DATA_W +: DATA_W];
      end else begin : g_old
        assign cap_win[(c*WINDOW_SIZE+k)*DATA_W +: DATA_W] =
          ring[wr_ptr + PTR_W'(k + 1)][c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) ring[wr_ptr] <= in_sample;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= FILL;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      stride_cnt <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      window     <= '0;
      win_count  <= '0;
    end else begin
      if (accept) begin
        if (in_last) begin
          state      <= FILL;
          wr_ptr     <= '0;
          fill_cnt   <= '0;
          stride_cnt <= '0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          if (state == FILL) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FC_W'(WINDOW_SIZE - 1)) state <= RUN;
          end else if (capture) begin
            stride_cnt <= '0;
          end else begin
            stride_cnt <= stride_cnt + 1'b1;
          end
        end
      end

      if (capture) begin
        out_valid <= 1'b1;
        out_last  <= in_last;
        window    <= cap_win;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (capture) begin
        if (wc_clear)                  win_count <= 16'd1;
        else if (win_count != 16'hFFFF) win_count <= win_count + 16'd1;
      end else if (wc_clear) begin
        win_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_mc.sv
// Directed bench for window_gen_mc: a STRIDE=2 instance for fill, stride, stall, trial
// and reset behaviour, plus a STRIDE=1 instance for back-to-back windows.
module tb_window_gen_mc;

  localparam int DW    = 16;
  localparam int WS    = 4;
  localparam int NCH   = 2;
  localparam int WIN_W = NCH * WS * DW;
  localparam int EXP_W = WIN_W + 17;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [NCH*DW-1:0] in_sample = '0;
  logic             in_ready, out_valid, out_last;
  logic [WIN_W-1:0] window;
  logic [15:0]      win_count;

  logic             in_valid1 = 1'b0, in_last1 = 1'b0, out_ready1 = 1'b1;
  logic [NCH*DW-1:0] in_sample1 = '0;
  logic             in_ready1, out_valid1, out_last1;
  logic [WIN_W-1:0] window1;
  logic [15:0]      win_count1;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp1_q[$];
  int total = 0;
  int bad = 0;

  window_gen_mc #(.DATA_W(DW), .WINDOW_SIZE(WS), .NUM_CH(NCH), .STRIDE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .window(window), .out_last(out_last), .win_count(win_count)
  );

  window_gen_mc #(.DATA_W(DW), .WINDOW_SIZE(WS), .NUM_CH(NCH), .STRIDE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_sample(in_sample1), .in_last(in_last1), .out_valid(out_valid1),
    .out_ready(out_ready1), .window(window1), .out_last(out_last1), .win_count(win_count1)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Window layout: channel c, tap k at [(c*WS+k)*DW]
  function automatic logic [WIN_W-1:0] mk_win(input logic [15:0] a0, a1, a2, a3,
                                             input logic [15:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0, a3, a2, a1, a0};
  endfunction

  function automatic logic [WIN_W-1:0] mk_seq(input int s);
    logic [15:0] a[4];
    logic [15:0] b[4];
    for (int k = 0; k < 4; k++) begin
      a[k] = 16'(s + k);
      b[k] = 16'(-(s + k));
    end
    return mk_win(a[0], a[1], a[2], a[3], b[0], b[1], b[2], b[3]);
  endfunction

  task automatic push0(input logic [WIN_W-1:0] w, input logic last, input int wc);
    exp_q.push_back({w, last, 16'(wc)});
  endtask

  task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: present one sample on the STRIDE=2 instance and hold until accepted.
  task automatic send(input int a, input int b, input logic last);
    int   waited;
    logic ok;
    in_valid  = 1'b1;
    in_sample = {16'(b), 16'(a)};
    in_last   = last;
    waited    = 0;
    ok        = 1'b0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      waited++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: sample %0d not taken within 50 cycles", a);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard monitors: pop and compare on every output handshake.
  task automatic mon0();
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_window: got %0h last=%0b wc=%0d expected none", window, out_last, win_count);
        end else begin
          e = exp_q.pop_front();
          if ({window, out_last, win_count} !== e) begin
            bad++;
            $display("FAIL window: got %0h last=%0b wc=%0d expected %0h last=%0b wc=%0d",
                     window, out_last, win_count, e[EXP_W-1:17], e[16], e[15:0]);
          end
        end
      end
    end
  endtask

  task automatic mon1();
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid1 && out_ready1) begin
        total++;
        if (exp1_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_window_s1: got %0h expected none", window1);
        end else begin
          e = exp1_q.pop_front();
          if ({window1, out_last1, win_count1} !== e) begin
            bad++;
            $display("FAIL window_s1: got %0h last=%0b wc=%0d expected %0h last=%0b wc=%0d",
                     window1, out_last1, win_count1, e[EXP_W-1:17], e[16], e[15:0]);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      mon0();
      mon1();
    join_none

    // Reset state
    #1;
    check("rst_out_valid", WIN_W'(out_valid), WIN_W'(0));
    check("rst_in_ready", WIN_W'(in_ready), WIN_W'(1));
    check("rst_out_last", WIN_W'(out_last), WIN_W'(0));
    check("rst_win_count", WIN_W'(win_count), WIN_W'(0));
    check("rst_window", window, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Fill and stride
    out_ready = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      if (n == 4) push0(mk_seq(1), 1'b0, 1);
      if (n == 6) push0(mk_seq(3), 1'b0, 2);
      if (n == 8) push0(mk_seq(5), 1'b0, 3);
      send(n, -n, 1'b0);
      check($sformatf("stride_valid_%0d", n), WIN_W'(out_valid),
            WIN_W'((n == 4 || n == 6 || n == 8) ? 1 : 0));
    end
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Backpressure
    out_ready = 1'b0;
    push0(mk_seq(1), 1'b0, 1);
    push0(mk_seq(3), 1'b0, 2);
    for (int n = 1; n <= 4; n++) send(n, -n, 1'b0);
    check("stall_in_ready", WIN_W'(in_ready), WIN_W'(0));
    fork
      begin
        send(5, -5, 1'b0);
        send(6, -6, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("stall_in_ready_held", WIN_W'(in_ready), WIN_W'(0));
        check("stall_out_valid", WIN_W'(out_valid), WIN_W'(1));
        check("stall_window", window, mk_seq(1));
        check("stall_win_count", WIN_W'(win_count), WIN_W'(1));
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Trial boundary
    for (int n = 1; n <= 5; n++) begin
      if (n == 4) push0(mk_seq(1), 1'b0, 1);
      send(n, -n, n == 5);
    end
    check("tail_win_count", WIN_W'(win_count), WIN_W'(0));
    check("tail_out_valid", WIN_W'(out_valid), WIN_W'(0));
    for (int n = 11; n <= 16; n++) begin
      if (n == 14) push0(mk_seq(11), 1'b0, 1);
      if (n == 16) push0(mk_seq(13), 1'b1, 2);
      send(n, -n, n == 16);
    end
    check("last_out_valid", WIN_W'(out_valid), WIN_W'(1));
    check("last_out_last", WIN_W'(out_last), WIN_W'(1));
    @(posedge clk); #1;
    check("last_wc_cleared", WIN_W'(win_count), WIN_W'(0));
    check("last_valid_cleared", WIN_W'(out_valid), WIN_W'(0));
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset mid-fill
    for (int n = 1; n <= 3; n++) send(n, -n, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_a", WIN_W'(out_valid), WIN_W'(0));
    @(posedge clk); #1;
    check("midrst_valid_b", WIN_W'(out_valid), WIN_W'(0));
    check("midrst_in_ready", WIN_W'(in_ready), WIN_W'(1));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push0(mk_seq(7), 1'b0, 1);
    for (int n = 7; n <= 10; n++) begin
      send(n, -n, 1'b0);
      check($sformatf("midrst_fill_%0d", n), WIN_W'(out_valid), WIN_W'((n == 10) ? 1 : 0));
    end
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Signed extremes
    push0(mk_win(16'h8000, 16'h8000, 16'h8000, 16'h8000,
                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0, 1);
    for (int n = 0; n < 4; n++) send(32'h8000, 32'h7FFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // STRIDE=1: back-to-back windows
    for (int s = 1; s <= 3; s++) exp1_q.push_back({mk_seq(s), 1'b0, 16'(s)});
    for (int n = 1; n <= 6; n++) begin
      in_valid1  = 1'b1;
      in_sample1 = {16'(-n), 16'(n)};
      @(posedge clk); #1;
      check($sformatf("s1_valid_%0d", n), WIN_W'(out_valid1), WIN_W'((n >= 4) ? 1 : 0));
    end
    in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("queue_empty", WIN_W'(exp_q.size()), WIN_W'(0));
    check("queue_empty_s1", WIN_W'(exp1_q.size()), WIN_W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
